// File: rtl/vram_arbiter_pkg.sv
// Shared display constants and the slot classification used by the VRAM arbiter.
package vram_arbiter_pkg;

    // Active display geometry in native (unscaled) pixels.
    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    // pix_x / pix_y carry this value while the raster is outside the active area.
    localparam logic [9:0] BLANK_XY = 10'h3FF;

    // Who owns the RAM port in the current cycle.
    typedef enum logic [1:0] {
        SLOT_WRITE    = 2'd0,
        SLOT_LINE     = 2'd1,
        SLOT_PREFETCH = 2'd2
    } slot_e;

endpackage

// File: rtl/vram_addr_gen.sv
// Framebuffer address from a (row, col) cell coordinate: row*FB_W + col.
module vram_addr_gen #(
    parameter int FB_W = 160,
    parameter int AW   = 15
) (
    input  logic [9:0]    row,
    input  logic [9:0]    col,
    output logic [AW-1:0] addr
);

    localparam logic [AW-1:0] FB_W_A = AW'(FB_W);

    // Row-major linear address, truncated to the RAM address width.
    assign addr = AW'(row) * FB_W_A + AW'(col);

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port framebuffer RAM between display fetch (fixed slots)
// and a valid/ready writer that gets every other cycle.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int SHIFT = 2,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    pix_x,
    input  logic [9:0]    pix_y,
    output logic [11:0]   pixel,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [11:0]   wr_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [11:0]   ram_wdata,
    input  logic [11:0]   ram_rdata,
    output logic          frame_done
);

    localparam int SCALE = 1 << SHIFT;
    localparam int FB_W  = H_ACT >> SHIFT;

    logic             active;
    logic [SHIFT-1:0] phase;
    logic [9:0]       col;
    logic [9:0]       row;
    logic [9:0]       nrow;
    slot_e            slot_kind;
    logic             disp_slot;
    logic [9:0]       gen_row;
    logic [9:0]       gen_col;
    logic [AW-1:0]    disp_addr;

    logic [9:0]  last_y_q,   last_y_d;
    logic        pf_done_q,  pf_done_d;
    logic        rd_pend_q,  rd_pend_d;
    logic        prev_act_q, prev_act_d;
    logic [11:0] pixel_q,    pixel_d;

    // Decode raster position and decide whether the display owns this cycle.
    always_comb begin
        active = (pix_x != BLANK_XY);
        phase  = pix_x[SHIFT-1:0];
        col    = pix_x >> SHIFT;
        row    = pix_y >> SHIFT;
        // After the last line, the next line to be shown is row 0 of the next frame.
        nrow   = (last_y_q == 10'(V_ACT - 1)) ? 10'd0 : (10'(last_y_q + 10'd1) >> SHIFT);

        slot_kind = SLOT_WRITE;
        if (active) begin
            // Fetch the next cell two cycles before it is shown; the last cell has no successor.
            if (phase == SHIFT'(SCALE - 2) && col != 10'(FB_W - 1)) begin
                slot_kind = SLOT_LINE;
            end
        end else if (!pf_done_q) begin
            slot_kind = SLOT_PREFETCH;
        end
        disp_slot = (slot_kind != SLOT_WRITE);

        gen_row = active ? row : nrow;
        gen_col = active ? 10'(col + 10'd1) : 10'd0;
    end

    vram_addr_gen #(
        .FB_W (FB_W),
        .AW   (AW)
    ) u_addr_gen (
        .row  (gen_row),
        .col  (gen_col),
        .addr (disp_addr)
    );

    // RAM port mux: display wins, otherwise the writer is offered the port.
    always_comb begin
        ram_wdata = wr_data;
        if (rst) begin
            ram_addr = '0;
            ram_we   = 1'b0;
            wr_ready = 1'b0;
        end else if (disp_slot) begin
            ram_addr = disp_addr;
            ram_we   = 1'b0;
            wr_ready = 1'b0;
        end else begin
            ram_addr = wr_addr;
            ram_we   = wr_valid;
            wr_ready = 1'b1;
        end
        frame_done = !rst && prev_act_q && !active && (last_y_q == 10'(V_ACT - 1));
        pixel      = pixel_q;
    end

    // Next-state: read capture, prefetch bookkeeping and line tracking.
    always_comb begin
        pixel_d    = rd_pend_q ? ram_rdata : pixel_q;
        rd_pend_d  = disp_slot;
        prev_act_d = active;
        last_y_d   = active ? pix_y : last_y_q;
        if (active) begin
            pf_done_d = 1'b0;
        end else if (disp_slot) begin
            pf_done_d = 1'b1;
        end else begin
            pf_done_d = pf_done_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_y_q   <= 10'(V_ACT - 1);
            pf_done_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            prev_act_q <= 1'b0;
            pixel_q    <= 12'd0;
        end else begin
            last_y_q   <= last_y_d;
            pf_done_q  <= pf_done_d;
            rd_pend_q  <= rd_pend_d;
            prev_act_q <= prev_act_d;
            pixel_q    <= pixel_d;
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (1-cycle read latency) between the display pixel fetch and a game-logic write port.
- Display fetch has fixed, guaranteed slots. The writer uses all remaining cycles through a valid/ready handshake.
- The block sits between vga_ctrl and the framebuffer BRAM. It consumes pix_x/pix_y (10'h3FF during blanking) and returns the pixel for the current position, replicated SCALE×SCALE.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- SHIFT, 2, log2 of scale factor; SCALE = 1<<SHIFT, must be ≥2
- FB_W, H_ACT>>SHIFT, framebuffer columns (160)
- FB_H, V_ACT>>SHIFT, framebuffer rows (120)
- AW, 15, framebuffer address width; must satisfy 2^AW ≥ FB_W*FB_H

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- pix_x  in  10  current display x; 10'h3FF = blanking
- pix_y  in  10  current display y; 10'h3FF = blanking
- pixel  out  12  RGB444 for current pix_x/pix_y, to vga_ctrl
- wr_valid  in  1  writer request
- wr_ready  out  1  write accepted this cycle when wr_valid&&wr_ready
- wr_addr  in  AW  framebuffer address, row*FB_W+col
- wr_data  in  12  RGB444 write data
- ram_addr  out  AW  RAM address, combinational
- ram_we  out  1  RAM write enable, combinational
- ram_wdata  out  12  RAM write data, combinational
- ram_rdata  in  12  RAM read data, valid the cycle after the address
- frame_done  out  1  one-cycle pulse after last active pixel of a frame

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset and while rst=1:
  - pixel=0, frame_done=0, wr_ready=0, ram_we=0, ram_addr=0.
  - Internal state: last_y=V_ACT-1, pf_done=0, rd_pend=0, prev_act=0.
- active = (pix_x != 10'h3FF). phase = pix_x[SHIFT-1:0]. col = pix_x>>SHIFT. row = pix_y>>SHIFT.
- Active-line slot: disp_slot when active && phase==SCALE-2 && col != FB_W-1.
  - Address issued: row*FB_W + col + 1.
  - There is no display slot in the last cell of a line; that slot goes to the writer.
- Blanking prefetch slot: disp_slot when !active && !pf_done.
  - Address issued: nrow*FB_W.
  - nrow = 0 if last_y==V_ACT-1, else (last_y+1)>>SHIFT.
  - pf_done is set on this cycle and cleared on any active cycle.
- Display always wins:
  - disp_slot=1: ram_addr=display address, ram_we=0, wr_ready=0, rd_pend<=1.
  - disp_slot=0: wr_ready=1 (combinational, independent of wr_valid), ram_addr=wr_addr, ram_wdata=wr_data, ram_we=wr_valid, rd_pend<=0.
- Capture: when rd_pend=1, pixel<=ram_rdata at end of that cycle.
  - Result: cell c+1 is read at phase SCALE-2 of cell c, and pixel holds it from the first cycle of cell c+1.
  - Cell 0 of each line holds the blanking-prefetched value.
- pixel changes only on capture; it may update during blanking (vga_ctrl masks it).
- last_y<=pix_y on every active cycle. prev_act<=active.
- frame_done=1 for exactly one cycle, when prev_act && !active && last_y==V_ACT-1.
  - This is the same cycle as the row-0 prefetch.
- Writer handshake: the writer must hold wr_addr/wr_data stable until accepted. No buffering and no write-to-read forwarding.
- Rejected cycles by construction:
  - One cycle per SCALE cycles while active, except the last cell of each line.
  - One cycle per blanking interval.
- Out-of-range wr_addr (≥FB_W*FB_H) is passed through unchecked.
- Reset mid-line:
  - All state returns to reset values.
  - The next blanking cycle after release fetches row 0, cell 0.
  - If rst releases mid-active, pixel shows 0 until the next capture.

Decomposition:
- The shared parameter include holds H_ACT, V_ACT and the 10'h3FF blanking sentinel; they are not duplicated locally.
- One natural sub-module: vram_addr_gen (combinational row*FB_W+col, AW-bit result).
- Slot decision, capture register and frame_done logic stay in vram_arbiter.

Test Plan:
1. Reset: assert rst with wr_valid=1 -> pixel=0, wr_ready=0, ram_we=0, frame_done=0. Release rst with pix_x=3FF -> ram_addr=0 and wr_ready=0 for one cycle.
2. Display fetch: RAM model mem[k]=k[11:0]; run row 0 after prefetch -> pixel=0 for pix_x 0..3 and 1 for 4..7; at pix_x=2, ram_addr=1, ram_we=0, wr_ready=0.
3. Row scaling: pix_y=5 -> at pix_x=2, ram_addr=161. On the blanking cycle after that line, ram_addr=160 (nrow=(5+1)>>2=1).
4. Writer saturation: wr_valid=1 throughout one active line -> 640-159=481 writes accepted. No write accepted at phase 2 for cols 0..158; the write at pix_x=638 is accepted.
5. Frame end: line 479 ends -> frame_done=1 for exactly one cycle, on the first pix_x=3FF cycle, with ram_addr=0. It stays 0 for the rest of vertical blanking.
6. Reset mid-line: assert rst at pix_x=300, pix_y=200 for 3 cycles -> outputs cleared. First blanking cycle after release fetches address 0 (not row 50).
